// File: rtl/hangman_pkg.sv
// Shared types and letter codes for the hangman game engine.
package hangman_pkg;

  // Game phases of the engine.
  typedef enum logic [2:0] {
    StIdle,
    StPlay,
    StCheck,
    StWin,
    StLose
  } state_e;

  // Letter-code width used by hangman_hex.
  localparam int unsigned HexLetterW = 6;

  // DASH is all-zeros and PAD is all-ones at any letter width.
  localparam logic [HexLetterW-1:0] DashCode = '0;
  localparam logic [HexLetterW-1:0] PadCode  = '1;

  // hangman_hex letter codes: A starts at 0x0A and runs contiguously.
  localparam logic [HexLetterW-1:0] LetterA = 6'h0A, LetterB = 6'h0B, LetterC = 6'h0C;
  localparam logic [HexLetterW-1:0] LetterD = 6'h0D, LetterE = 6'h0E, LetterF = 6'h0F;
  localparam logic [HexLetterW-1:0] LetterG = 6'h10, LetterH = 6'h11, LetterI = 6'h12;
  localparam logic [HexLetterW-1:0] LetterJ = 6'h13, LetterK = 6'h14, LetterL = 6'h15;
  localparam logic [HexLetterW-1:0] LetterM = 6'h16, LetterN = 6'h17, LetterO = 6'h18;
  localparam logic [HexLetterW-1:0] LetterP = 6'h19, LetterQ = 6'h1A, LetterR = 6'h1B;
  localparam logic [HexLetterW-1:0] LetterS = 6'h1C, LetterT = 6'h1D, LetterU = 6'h1E;
  localparam logic [HexLetterW-1:0] LetterV = 6'h1F, LetterW = 6'h20, LetterX = 6'h21;
  localparam logic [HexLetterW-1:0] LetterY = 6'h22;

endpackage

// File: rtl/hangman_letter_match.sv
// Compares one guessed letter against every position of a word.
module hangman_letter_match
  import hangman_pkg::*;
#(
  parameter int unsigned WORD_LEN = 4,
  parameter int unsigned LETTER_W = 6
) (
  input  logic [WORD_LEN*LETTER_W-1:0] word,
  input  logic [LETTER_W-1:0]          guess,
  output logic [WORD_LEN-1:0]          hit_mask,
  output logic                         any_hit
);

  // Per-position equality; double letters light several bits at once.
  always_comb begin
    hit_mask = '0;
    for (int i = 0; i < WORD_LEN; i++) begin
      hit_mask[i] = (word[i*LETTER_W +: LETTER_W] == guess);
    end
  end

  assign any_hit = |hit_mask;

endmodule

// File: rtl/hangman_game_engine.sv
// Hangman controller: word latch, reveal mask, wrong-guess count, win/lose status.
module hangman_game_engine
  import hangman_pkg::*;
#(
  parameter int unsigned WORD_LEN   = 4,
  parameter int unsigned LETTER_W   = 6,
  parameter int unsigned MAX_WRONGS = 4,
  parameter int unsigned CNT_W      = 3
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [WORD_LEN*LETTER_W-1:0] word_in,
  input  logic                         word_load,
  input  logic [LETTER_W-1:0]          guess,
  input  logic                         guess_valid,
  input  logic                         timer_expired,
  input  logic                         new_game,
  output logic [WORD_LEN*LETTER_W-1:0] display,
  output logic [WORD_LEN-1:0]          revealed,
  output logic [CNT_W-1:0]             wrong_count,
  output logic                         result_valid,
  output logic                         result_correct,
  output logic                         result_repeat,
  output logic                         game_won,
  output logic                         game_lost,
  output logic                         playing
);

  localparam int unsigned          NumCodes  = 2 ** LETTER_W;
  localparam logic [LETTER_W-1:0]  Dash      = '0;
  localparam logic [LETTER_W-1:0]  Pad       = '1;
  localparam logic [CNT_W-1:0]     MaxWrongs = CNT_W'(MAX_WRONGS);

  state_e                        state_q, state_d;
  logic [WORD_LEN*LETTER_W-1:0]  word_q, word_d;
  logic [WORD_LEN-1:0]           revealed_q, revealed_d;
  logic [CNT_W-1:0]              wrong_count_q, wrong_count_d;
  logic [NumCodes-1:0]           guessed_q, guessed_d;
  logic [LETTER_W-1:0]           guess_q, guess_d;
  logic                          result_valid_d, result_correct_d, result_repeat_d;
  logic                          result_valid_q, result_correct_q, result_repeat_q;
  logic [WORD_LEN*LETTER_W-1:0]  display_q, display_d;
  logic                          game_won_q, game_lost_q, playing_q;
  logic [WORD_LEN-1:0]           hit_mask;
  logic                          any_hit;
  logic                          guess_legal;

  assign guess_legal = (guess != Dash) && (guess != Pad);

  hangman_letter_match #(
    .WORD_LEN (WORD_LEN),
    .LETTER_W (LETTER_W)
  ) u_match (
    .word     (word_q),
    .guess    (guess_q),
    .hit_mask (hit_mask),
    .any_hit  (any_hit)
  );

  // Next-state and judgement logic; new_game overrides every other input.
  always_comb begin
    state_d          = state_q;
    word_d           = word_q;
    revealed_d       = revealed_q;
    wrong_count_d    = wrong_count_q;
    guessed_d        = guessed_q;
    guess_d          = guess_q;
    result_valid_d   = 1'b0;
    result_correct_d = 1'b0;
    result_repeat_d  = 1'b0;
    if (new_game) begin
      state_d       = StIdle;
      revealed_d    = '0;
      wrong_count_d = '0;
      guessed_d     = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (word_load) begin
            word_d = word_in;
            // Pad positions count as already revealed.
            for (int i = 0; i < WORD_LEN; i++) begin
              revealed_d[i] = (word_in[i*LETTER_W +: LETTER_W] == Pad);
            end
            state_d = (&revealed_d) ? StWin : StPlay;
          end
        end
        StPlay: begin
          if (timer_expired) begin
            state_d = StLose;
          end else if (guess_valid && guess_legal) begin
            guess_d = guess;
            state_d = StCheck;
          end
        end
        StCheck: begin
          if (timer_expired) begin
            state_d = StLose;
          end else begin
            result_valid_d = 1'b1;
            if (guessed_q[guess_q]) begin
              // Repeats are reported but never penalised.
              result_repeat_d  = 1'b1;
              result_correct_d = any_hit;
            end else begin
              guessed_d[guess_q] = 1'b1;
              if (any_hit) begin
                result_correct_d = 1'b1;
                revealed_d       = revealed_q | hit_mask;
              end else if (wrong_count_q < MaxWrongs) begin
                wrong_count_d = wrong_count_q + 1'b1;
              end
            end
            if (&revealed_d) begin
              state_d = StWin;
            end else if (wrong_count_d == MaxWrongs) begin
              state_d = StLose;
            end else begin
              state_d = StPlay;
            end
          end
        end
        StWin, StLose: ;
        default: state_d = StIdle;
      endcase
    end
  end

  // Display is built from next-state values so it updates with the reveal mask.
  always_comb begin
    display_d = '0;
    for (int i = 0; i < WORD_LEN; i++) begin
      if (state_d == StIdle) begin
        display_d[i*LETTER_W +: LETTER_W] = Dash;
      end else if (word_d[i*LETTER_W +: LETTER_W] == Pad) begin
        display_d[i*LETTER_W +: LETTER_W] = Pad;
      end else if (revealed_d[i] || (state_d == StLose)) begin
        display_d[i*LETTER_W +: LETTER_W] = word_d[i*LETTER_W +: LETTER_W];
      end else begin
        display_d[i*LETTER_W +: LETTER_W] = Dash;
      end
    end
  end

  // State and registered outputs; reset wins over new_game.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= StIdle;
      word_q           <= '0;
      revealed_q       <= '0;
      wrong_count_q    <= '0;
      guessed_q        <= '0;
      guess_q          <= '0;
      result_valid_q   <= 1'b0;
      result_correct_q <= 1'b0;
      result_repeat_q  <= 1'b0;
      display_q        <= '0;
      game_won_q       <= 1'b0;
      game_lost_q      <= 1'b0;
      playing_q        <= 1'b0;
    end else begin
      state_q          <= state_d;
      word_q           <= word_d;
      revealed_q       <= revealed_d;
      wrong_count_q    <= wrong_count_d;
      guessed_q        <= guessed_d;
      guess_q          <= guess_d;
      result_valid_q   <= result_valid_d;
      result_correct_q <= result_correct_d;
      result_repeat_q  <= result_repeat_d;
      display_q        <= display_d;
      game_won_q       <= (state_d == StWin);
      game_lost_q      <= (state_d == StLose);
      playing_q        <= (state_d == StPlay) || (state_d == StCheck);
    end
  end

  assign display        = display_q;
  assign revealed       = revealed_q;
  assign wrong_count    = wrong_count_q;
  assign result_valid   = result_valid_q;
  assign result_correct = result_correct_q;
  assign result_repeat  = result_repeat_q;
  assign game_won       = game_won_q;
  assign game_lost      = game_lost_q;
  assign playing        = playing_q;

endmodule

// File: tb/tb_hangman_game_engine.sv
// Randomized and directed bench for hangman_game_engine against a game-level model.
module tb_hangman_game_engine;
  import hangman_pkg::*;

  localparam int unsigned WL   = 5;
  localparam int unsigned LW   = 6;
  localparam int unsigned MAXW = 4;
  localparam int unsigned CW   = 3;
  localparam logic [LW-1:0] PadC = '1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset, new_game, word_load, guess_valid, timer_expired;
  logic [WL*LW-1:0]  word_in;
  logic [LW-1:0]     guess;
  logic [WL*LW-1:0]  display;
  logic [WL-1:0]     revealed;
  logic [CW-1:0]     wrong_count;
  logic              result_valid, result_correct, result_repeat;
  logic              game_won, game_lost, playing;

  int n_checks = 0;
  int n_fail   = 0;

  hangman_game_engine #(
    .WORD_LEN   (WL),
    .LETTER_W   (LW),
    .MAX_WRONGS (MAXW),
    .CNT_W      (CW)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .word_in        (word_in),
    .word_load      (word_load),
    .guess          (guess),
    .guess_valid    (guess_valid),
    .timer_expired  (timer_expired),
    .new_game       (new_game),
    .display        (display),
    .revealed       (revealed),
    .wrong_count    (wrong_count),
    .result_valid   (result_valid),
    .result_correct (result_correct),
    .result_repeat  (result_repeat),
    .game_won       (game_won),
    .game_lost      (game_lost),
    .playing        (playing)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Game-level reference: phase of play, letters, reveal flags, set of guessed letters.
  typedef enum int {MIdle, MPlay, MPending, MWon, MLost} phase_e;
  phase_e       m_phase;
  logic [LW-1:0] m_word [WL];
  bit           m_rev  [WL];
  bit           m_seen [64];
  int           m_wrong;
  logic [LW-1:0] m_pend;
  bit           m_rv, m_rc, m_rr;

  task automatic model_clear();
    m_phase = MIdle;
    m_wrong = 0;
    for (int i = 0; i < int'(WL); i++) m_rev[i] = 1'b0;
    for (int i = 0; i < 64; i++) m_seen[i] = 1'b0;
  endtask

  task automatic judge();
    int  hits;
    bit  all_rev;
    hits = 0;
    for (int i = 0; i < int'(WL); i++) if (m_word[i] == m_pend) hits++;
    m_rv = 1'b1;
    if (m_seen[m_pend]) begin
      m_rr = 1'b1;
      m_rc = (hits > 0);
    end else begin
      m_seen[m_pend] = 1'b1;
      if (hits > 0) begin
        m_rc = 1'b1;
        for (int i = 0; i < int'(WL); i++) if (m_word[i] == m_pend) m_rev[i] = 1'b1;
      end else if (m_wrong < int'(MAXW)) begin
        m_wrong++;
      end
    end
    all_rev = 1'b1;
    for (int i = 0; i < int'(WL); i++) all_rev &= m_rev[i];
    if (all_rev) m_phase = MWon;
    else if (m_wrong == int'(MAXW)) m_phase = MLost;
    else m_phase = MPlay;
  endtask

  task automatic model_edge();
    bit all_pad;
    m_rv = 1'b0;
    m_rc = 1'b0;
    m_rr = 1'b0;
    if (reset || new_game) begin
      model_clear();
    end else begin
      case (m_phase)
        MIdle: if (word_load) begin
          all_pad = 1'b1;
          for (int i = 0; i < int'(WL); i++) begin
            m_word[i] = word_in[i*LW +: LW];
            m_rev[i]  = (m_word[i] == PadC);
            all_pad  &= m_rev[i];
          end
          m_phase = all_pad ? MWon : MPlay;
        end
        MPlay: begin
          if (timer_expired) m_phase = MLost;
          else if (guess_valid && guess != '0 && guess != PadC) begin
            m_pend  = guess;
            m_phase = MPending;
          end
        end
        MPending: begin
          if (timer_expired) m_phase = MLost;
          else judge();
        end
        default: ;
      endcase
    end
  endtask

  task automatic compare_all();
    logic [WL*LW-1:0] ed;
    logic [WL-1:0]    er;
    for (int i = 0; i < int'(WL); i++) begin
      er[i] = m_rev[i];
      if (m_phase == MIdle) ed[i*LW +: LW] = '0;
      else if (m_word[i] == PadC) ed[i*LW +: LW] = PadC;
      else if (m_rev[i] || m_phase == MLost) ed[i*LW +: LW] = m_word[i];
      else ed[i*LW +: LW] = '0;
    end
    check("m_display", 64'(display), 64'(ed));
    check("m_revealed", 64'(revealed), 64'(er));
    check("m_wrong", 64'(wrong_count), 64'(m_wrong));
    check("m_rvalid", 64'(result_valid), 64'(m_rv));
    if (m_rv) begin
      check("m_rcorrect", 64'(result_correct), 64'(m_rc));
      check("m_rrepeat", 64'(result_repeat), 64'(m_rr));
    end
    check("m_won", 64'(game_won), 64'(m_phase == MWon));
    check("m_lost", 64'(game_lost), 64'(m_phase == MLost));
    check("m_playing", 64'(playing), 64'(m_phase == MPlay || m_phase == MPending));
  endtask

  // One clock: DUT and model see the same inputs, then pulses drop.
  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
    reset         = 1'b0;
    new_game      = 1'b0;
    word_load     = 1'b0;
    guess_valid   = 1'b0;
    timer_expired = 1'b0;
  endtask

  task automatic load(input logic [WL*LW-1:0] w);
    word_in   = w;
    word_load = 1'b1;
    cycle();
  endtask

  task automatic play_guess(input logic [LW-1:0] g);
    guess       = g;
    guess_valid = 1'b1;
    cycle();
    cycle();
  endtask

  function automatic logic [WL*LW-1:0] mk(input logic [LW-1:0] l0, l1, l2, l3, l4);
    return {l4, l3, l2, l1, l0};
  endfunction

  logic [WL*LW-1:0] w_stay, w_darn, w_head, w_leaf, w_rand;
  int r;

  initial begin
    reset = 1'b1; new_game = 1'b0; word_load = 1'b0; guess_valid = 1'b0;
    timer_expired = 1'b0; guess = '0; word_in = '0;
    m_rv = 1'b0; m_rc = 1'b0; m_rr = 1'b0; m_pend = '0;
    for (int i = 0; i < int'(WL); i++) m_word[i] = '0;
    model_clear();
    w_stay = mk(LetterS, LetterT, LetterA, LetterY, PadC);
    w_darn = mk(LetterD, LetterA, LetterR, LetterN, PadC);
    w_head = mk(LetterH, LetterE, LetterA, LetterD, PadC);
    w_leaf = mk(LetterL, LetterE, LetterA, LetterF, PadC);

    reset = 1'b1;
    cycle();
    check("rst_display", 64'(display), 64'd0);
    check("rst_revealed", 64'(revealed), 64'd0);
    check("rst_status", 64'({result_valid, result_correct, result_repeat, game_won, game_lost,
                              playing}), 64'd0);

    // Win
    load(w_stay);
    check("stay_load_rev", 64'(revealed), 64'b10000);
    play_guess(LetterS); check("stay_s_rev", 64'(revealed), 64'b10001);
    check("stay_s_ok", 64'({result_valid, result_correct}), 64'b11);
    play_guess(LetterT); check("stay_t_rev", 64'(revealed), 64'b10011);
    play_guess(LetterA); check("stay_a_rev", 64'(revealed), 64'b10111);
    play_guess(LetterY); check("stay_y_rev", 64'(revealed), 64'b11111);
    check("stay_won", 64'({game_won, game_lost, playing}), 64'b100);
    check("stay_disp", 64'(display), 64'(w_stay));
    check("stay_wrong", 64'(wrong_count), 64'd0);

    // Lose
    new_game = 1'b1; cycle();
    load(w_darn);
    play_guess(LetterE); check("darn_w1", 64'(wrong_count), 64'd1);
    check("darn_miss", 64'({result_valid, result_correct}), 64'b10);
    play_guess(LetterF); check("darn_w2", 64'(wrong_count), 64'd2);
    play_guess(LetterG); check("darn_w3", 64'(wrong_count), 64'd3);
    play_guess(LetterH); check("darn_w4", 64'(wrong_count), 64'd4);
    check("darn_lost", 64'({game_won, game_lost}), 64'b01);
    check("darn_disp", 64'(display), 64'(w_darn));

    // Repeats
    new_game = 1'b1; cycle();
    load(w_head);
    play_guess(LetterE);
    play_guess(LetterE);
    check("head_e_rep", 64'({result_valid, result_correct, result_repeat}), 64'b111);
    play_guess(LetterL);
    play_guess(LetterL);
    check("head_l_rep", 64'({result_valid, result_correct, result_repeat}), 64'b101);
    check("head_wrong", 64'(wrong_count), 64'd1);

    // Pad position and illegal codes
    new_game = 1'b1; cycle();
    load(w_leaf);
    check("leaf_load_rev", 64'(revealed), 64'b10000);
    play_guess(LetterA); check("leaf_a_rev", 64'(revealed), 64'b10100);
    play_guess(PadC); check("leaf_pad_guess", 64'({result_valid, playing}), 64'b01);
    play_guess('0); check("leaf_dash_guess", 64'({result_valid, playing}), 64'b01);

    // Timer expiring during the check cycle
    new_game = 1'b1; cycle();
    load(w_stay);
    guess = LetterS; guess_valid = 1'b1; cycle();
    timer_expired = 1'b1; cycle();
    check("tmr_lost", 64'({game_lost, result_valid}), 64'b10);
    check("tmr_rev", 64'(revealed), 64'b10000);
    play_guess(LetterT);
    check("tmr_ignore", 64'({game_lost, result_valid, revealed}), 64'b1010000);

    // Restart, reset priority, load ignored while playing
    new_game = 1'b1; cycle();
    load(w_head);
    play_guess(LetterL);
    new_game = 1'b1; cycle();
    check("ng_clear", 64'({wrong_count, revealed, playing, game_lost}), 64'd0);
    check("ng_disp", 64'(display), 64'd0);
    load(w_head);
    reset = 1'b1; new_game = 1'b1; cycle();
    check("rst_ng", 64'({playing, revealed}), 64'd0);
    load(w_darn);
    word_in = w_head; word_load = 1'b1; cycle();
    play_guess(LetterH);
    check("load_in_play", 64'({result_correct, wrong_count}), 64'({1'b0, 3'd1}));

    // Randomized games
    for (int g = 0; g < 150; g++) begin
      if ($urandom_range(0, 3) == 0) reset = 1'b1;
      else new_game = 1'b1;
      cycle();
      for (int i = 0; i < int'(WL); i++) begin
        r = $urandom_range(0, 9);
        w_rand[i*LW +: LW] = (r == 0) ? PadC : LW'(LetterA + $urandom_range(0, 5));
      end
      load(w_rand);
      for (int c = 0; c < 30; c++) begin
        guess_valid = 1'($urandom_range(0, 1));
        r = $urandom_range(0, 15);
        guess = (r == 0) ? '0 : (r == 1) ? PadC : LW'(LetterA + $urandom_range(0, 9));
        timer_expired = ($urandom_range(0, 99) == 0);
        word_load = ($urandom_range(0, 19) == 0);
        word_in = WL*LW'($urandom());
        new_game = ($urandom_range(0, 99) == 0);
        cycle();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
